// File: rtl/bram_burst_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_burst_collector_if
// Purpose  : Bundles the control, BRAM-read and snapshot signals of
//            bram_burst_collector into one port.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals
//   start       requester -> collector  level; a 0->1 transition requests a burst
//   start_addr  requester -> collector  first BRAM address of the burst
//   data_in     BRAM      -> collector  read data
//   addr        collector -> BRAM       read address
//   rd_en       collector -> BRAM       read enable
//   data_out    collector -> packer     DEPTH words; the first word read is the MS slice
//   busy        collector -> requester  a burst is in progress
//   data_valid  collector -> packer     one-cycle pulse; data_out is complete
// Modports
//   slave  : the collector side
//   master : the environment side (requester, BRAM, packer)
// ============================================================================
interface bram_burst_collector_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = 9
);
  logic                        start;
  logic [ADDR_WIDTH-1:0]       start_addr;
  logic [DATA_WIDTH-1:0]       data_in;
  logic [ADDR_WIDTH-1:0]       addr;
  logic                        rd_en;
  logic [DATA_WIDTH*DEPTH-1:0] data_out;
  logic                        busy;
  logic                        data_valid;

  modport slave (
    input  start,
    input  start_addr,
    input  data_in,
    output addr,
    output rd_en,
    output data_out,
    output busy,
    output data_valid
  );

  modport master (
    output start,
    output start_addr,
    output data_in,
    input  addr,
    input  rd_en,
    input  data_out,
    input  busy,
    input  data_valid
  );
endinterface
`default_nettype wire

// File: rtl/bram_burst_collector.sv
`default_nettype none
// ============================================================================
// Module   : bram_burst_collector
// Purpose  : When start rises, reads DEPTH consecutive BRAM words from a
//            runtime start address, with the address wrapping around. The
//            returned words are shifted into a wide snapshot register. A
//            one-cycle data_valid pulse marks the point where the snapshot is
//            complete.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH  width of one BRAM word
//   DEPTH       words per burst (1 .. 2**ADDR_WIDTH)
//   ADDR_WIDTH  BRAM address width
//   RD_LATENCY  cycles from addr/rd_en to valid data_in (1 .. 4)
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   bus         bram_burst_collector_if.slave (start, start_addr, data_in,
//               addr, rd_en, data_out, busy, data_valid)
// Build option
//   BRAM_COLLECT_DOWN_EN  defined: the address decrements through the burst.
//                         undefined: the address increments.
//                         Capture order and timing are the same in both builds.
// ============================================================================
module bram_burst_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = 9,
  parameter int RD_LATENCY = 1
) (
  input wire clk,
  input wire rst,
  bram_burst_collector_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = DATA_WIDTH * DEPTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q,     state_d;
  logic [1:0]            start_r_q,   start_r_d;
  // hist_q[n] means start_r_q[n] holds a real post-reset sample of start.
  logic [1:0]            hist_q,      hist_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic                  rd_en_q,     rd_en_d;
  logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]      cap_cnt_q,   cap_cnt_d;
  logic [RD_LATENCY-1:0] dly_q,       dly_d;
  logic [OUT_W-1:0]      data_out_q,  data_out_d;

  logic                  start_pulse;
  logic                  cap_en;
  logic                  last_cap;
  logic [ADDR_WIDTH-1:0] addr_step;
  logic [OUT_W-1:0]      shifted;

  // --------------------------------------------------------------------------
  // Start edge detection
  // --------------------------------------------------------------------------
  // After reset, start_r_q reads 2'b00. That value is a reset artefact and
  // not a real sample. Without the hist_q qualifier, a start held high
  // through reset release would look like a rising edge.
  always_comb begin
    start_r_d = {start_r_q[0], bus.start};
    hist_d    = {hist_q[0], 1'b1};
  end

  assign start_pulse = start_r_q[0] & ~start_r_q[1] & hist_q[1] &
                       (state_q == S_IDLE);

  // --------------------------------------------------------------------------
  // Address stepping (modulo 2**ADDR_WIDTH by natural overflow)
  // --------------------------------------------------------------------------
`ifdef BRAM_COLLECT_DOWN_EN
  assign addr_step = addr_q - ADDR_WIDTH'(1);
`else
  assign addr_step = addr_q + ADDR_WIDTH'(1);
`endif

  // --------------------------------------------------------------------------
  // Capture enable: rd_en_d delayed by RD_LATENCY flops. This equals rd_en_q
  // delayed by RD_LATENCY-1 cycles, which makes word k land at edge
  // E1+k+RD_LATENCY.
  // --------------------------------------------------------------------------
  generate
    if (RD_LATENCY == 1) begin : g_dly_single
      assign dly_d = rd_en_d;
    end else begin : g_dly_chain
      assign dly_d = {dly_q[RD_LATENCY-2:0], rd_en_d};
    end
  endgenerate

  assign cap_en   = dly_q[RD_LATENCY-1];
  assign last_cap = cap_en & (cap_cnt_q == CNT_W'(DEPTH - 1));

  // --------------------------------------------------------------------------
  // Snapshot shift: new words enter at the LS slice. The first word read
  // therefore ends up in the MS slice.
  // --------------------------------------------------------------------------
  generate
    if (DEPTH == 1) begin : g_shift_single
      assign shifted = bus.data_in;
    end else begin : g_shift_multi
      assign shifted = {data_out_q[OUT_W-DATA_WIDTH-1:0], bus.data_in};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_en_d     = 1'b0;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    data_out_d  = data_out_q;

    if (cap_en) begin
      data_out_d = shifted;
      cap_cnt_d  = cap_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start_pulse) begin
          state_d     = S_READ;
          addr_d      = bus.start_addr;
          rd_en_d     = 1'b1;
          issue_cnt_d = CNT_W'(1);
          cap_cnt_d   = '0;
        end
      end

      S_READ: begin
        if (issue_cnt_q == CNT_W'(DEPTH)) begin
          // With RD_LATENCY == 1, the final capture happens on the same edge
          // that ends the read phase, so DRAIN is skipped.
          state_d = last_cap ? S_DONE : S_DRAIN;
        end else begin
          addr_d      = addr_step;
          rd_en_d     = 1'b1;
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
        end
      end

      S_DRAIN: begin
        if (last_cap) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      start_r_q   <= 2'b00;
      hist_q      <= 2'b00;
      addr_q      <= '0;
      rd_en_q     <= 1'b0;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      dly_q       <= '0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      start_r_q   <= start_r_d;
      hist_q      <= hist_d;
      addr_q      <= addr_d;
      rd_en_q     <= rd_en_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      dly_q       <= dly_d;
      data_out_q  <= data_out_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.addr       = addr_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.data_out   = data_out_q;
  assign bus.busy       = (state_q == S_READ) | (state_q == S_DRAIN);
  assign bus.data_valid = (state_q == S_DONE);

endmodule
`default_nettype wire
